// File: rtl/two_channel_mux_arbiter.sv
// Round-robin two-channel arbiter with bounded bursts and a registered output stage.
// Optional per-channel saturating grant counters under GRANT_COUNT_EN.
module two_channel_mux_arbiter #(
    parameter int WIDTH     = 4,
    parameter int BURST_LEN = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In_0,
    input  logic             Valid_0,
    output logic             Ready_0,
    input  logic [WIDTH-1:0] In_1,
    input  logic             Valid_1,
    output logic             Ready_1,
    output logic             Select,
    output logic [WIDTH-1:0] Out,
    output logic             Out_Valid,
    input  logic             Out_Ready
`ifdef GRANT_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] Grant_Count_0,
    output logic [CNT_WIDTH-1:0] Grant_Count_1
`endif
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST_LEN);

    state_t         state, state_nx;
    logic [BW-1:0]  burst, burst_nx, burst_inc;
    logic           last;
    logic           take;
    logic           xfer_0, xfer_1;

    assign take      = !Out_Valid || Out_Ready;
    assign Ready_0   = (state == OWN0) && take;
    assign Ready_1   = (state == OWN1) && take;
    assign xfer_0    = Valid_0 && Ready_0;
    assign xfer_1    = Valid_1 && Ready_1;
    assign Select    = (state == OWN1);
    assign burst_inc = (burst == BMAX) ? BMAX : burst + 1'b1;

    always_comb begin
        state_nx = state;
        burst_nx = burst;
        unique case (state)
            IDLE: begin
                burst_nx = '0;
                if (Valid_0 && Valid_1)
                    state_nx = last ? OWN0 : OWN1;
                else if (Valid_0)
                    state_nx = OWN0;
                else if (Valid_1)
                    state_nx = OWN1;
            end
            OWN0: begin
                if (!Valid_0) begin
                    state_nx = Valid_1 ? OWN1 : IDLE;
                    burst_nx = '0;
                end else if (xfer_0) begin
                    if (burst_inc == BMAX && Valid_1) begin
                        state_nx = OWN1;
                        burst_nx = '0;
                    end else begin
                        burst_nx = burst_inc;
                    end
                end
            end
            OWN1: begin
                if (!Valid_1) begin
                    state_nx = Valid_0 ? OWN0 : IDLE;
                    burst_nx = '0;
                end else if (xfer_1) begin
                    if (burst_inc == BMAX && Valid_0) begin
                        state_nx = OWN0;
                        burst_nx = '0;
                    end else begin
                        burst_nx = burst_inc;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                burst_nx = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            burst     <= '0;
            last      <= 1'b1;
            Out       <= '0;
            Out_Valid <= 1'b0;
        end else begin
            state <= state_nx;
            burst <= burst_nx;
            if (xfer_0 || xfer_1) begin
                Out       <= Select ? In_1 : In_0;
                Out_Valid <= 1'b1;
                last      <= xfer_1;
            end else if (Out_Ready) begin
                Out_Valid <= 1'b0;
            end
        end
    end

`ifdef GRANT_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Grant_Count_0 <= '0;
            Grant_Count_1 <= '0;
        end else begin
            if (xfer_0 && Grant_Count_0 != '1)
                Grant_Count_0 <= Grant_Count_0 + 1'b1;
            if (xfer_1 && Grant_Count_1 != '1)
                Grant_Count_1 <= Grant_Count_1 + 1'b1;
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_two_channel_mux_arbiter.sv
// Randomized and directed bench for two_channel_mux_arbiter against a
// transaction-level reference model of the arbitration rules.
module tb_two_channel_mux_arbiter;

    localparam int W  = 4;
    localparam int BL = 2;
    localparam int CW = 2;

    logic         Clock = 1'b0;
    logic         Reset;
    logic [W-1:0] In_0, In_1;
    logic         Valid_0, Valid_1, Out_Ready;
    logic         Ready_0, Ready_1, Select, Out_Valid;
    logic [W-1:0] Out;
`ifdef GRANT_COUNT_EN
    logic [CW-1:0] gc0, gc1;
`endif

    two_channel_mux_arbiter #(.WIDTH(W), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
        .Clock(Clock), .Reset(Reset),
        .In_0(In_0), .Valid_0(Valid_0), .Ready_0(Ready_0),
        .In_1(In_1), .Valid_1(Valid_1), .Ready_1(Ready_1),
        .Select(Select), .Out(Out), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready)
`ifdef GRANT_COUNT_EN
        , .Grant_Count_0(gc0), .Grant_Count_1(gc1)
`endif
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    // reference model: owner -1 = nobody, run = transfers in current burst
    int           m_own, m_run, m_last, m_ov, m_acc;
    logic [W-1:0] m_out;
    int           m_gc0, m_gc1;
    int           gmax = (1 << CW) - 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(bit r, bit v0, bit v1,
                                logic [W-1:0] d0, logic [W-1:0] d1, bit ordy);
        bit vv[2];
        int acc, other;
        vv[0] = v0;
        vv[1] = v1;
        if (r) begin
            m_own = -1; m_run = 0; m_last = 1; m_ov = 0;
            m_out = '0; m_gc0 = 0; m_gc1 = 0; m_acc = -1;
            return;
        end
        acc = -1;
        if (m_own >= 0 && vv[m_own] && (m_ov == 0 || ordy)) acc = m_own;
        m_acc = acc;
        if (acc >= 0) begin
            m_out  = (acc == 1) ? d1 : d0;
            m_ov   = 1;
            m_last = acc;
            if (acc == 0 && m_gc0 < gmax) m_gc0++;
            if (acc == 1 && m_gc1 < gmax) m_gc1++;
        end else if (ordy) begin
            m_ov = 0;
        end
        if (m_own < 0) begin
            m_run = 0;
            if (v0 && v1) m_own = 1 - m_last;
            else if (v0)  m_own = 0;
            else if (v1)  m_own = 1;
        end else begin
            other = 1 - m_own;
            if (!vv[m_own]) begin
                m_own = vv[other] ? other : -1;
                m_run = 0;
            end else if (acc >= 0) begin
                m_run = (m_run + 1 > BL) ? BL : m_run + 1;
                if (m_run == BL && vv[other]) begin
                    m_own = other;
                    m_run = 0;
                end
            end
        end
    endtask

    task automatic step(bit r, bit v0, bit v1,
                        logic [W-1:0] d0, logic [W-1:0] d1, bit ordy);
        Reset = r; Valid_0 = v0; Valid_1 = v1;
        In_0 = d0; In_1 = d1; Out_Ready = ordy;
        #2;
        chk("ready0", 32'(Ready_0), 32'(m_own == 0 && (m_ov == 0 || ordy)));
        chk("ready1", 32'(Ready_1), 32'(m_own == 1 && (m_ov == 0 || ordy)));
        chk("select", 32'(Select), 32'(m_own == 1));
        chk("out_valid", 32'(Out_Valid), 32'(m_ov));
        chk("out", 32'(Out), 32'(m_out));
`ifdef GRANT_COUNT_EN
        chk("gc0", 32'(gc0), 32'(m_gc0));
        chk("gc1", 32'(gc1), 32'(m_gc1));
`endif
        model_update(r, v0, v1, d0, d1, ordy);
        @(posedge Clock);
        #1;
    endtask

    logic [W-1:0] seq [8];
    logic [W-1:0] want [8];

    initial begin
        bit           v0, v1, rdy;
        logic [W-1:0] d0, d1;

        Reset = 1'b1; Valid_0 = 1'b1; Valid_1 = 1'b1;
        In_0 = '0; In_1 = '0; Out_Ready = 1'b1;
        model_update(1, 1, 1, '0, '0, 1);
        @(posedge Clock);
        #1;

        // reset with both valid, then contention 3,3,C,C,...
        step(1, 1, 1, 4'h3, 4'hC, 1);
        step(1, 1, 1, 4'h3, 4'hC, 1);
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_select", 32'(Select), 32'd0);
        step(0, 1, 1, 4'h3, 4'hC, 1);
        chk("own0_first", 32'(Ready_0), 32'd1);
        step(0, 1, 1, 4'h3, 4'hC, 1);
        want[0] = 4'h3; want[1] = 4'h3; want[2] = 4'hC; want[3] = 4'hC;
        want[4] = 4'h3; want[5] = 4'h3; want[6] = 4'hC; want[7] = 4'hC;
        for (int i = 0; i < 8; i++) begin
            #2;
            seq[i] = Out;
            chk("contend_valid", 32'(Out_Valid), 32'd1);
            chk("contend_seq", 32'(seq[i]), 32'(want[i]));
            #1;
            step(0, 1, 1, 4'h3, 4'hC, 1);
        end

        // single channel 1
        step(1, 0, 0, '0, '0, 1);
        step(0, 0, 1, '0, 4'hA, 1);
        chk("single_sel", 32'(Select), 32'd1);
        step(0, 0, 1, '0, 4'hA, 1);
        chk("single_out", 32'(Out), 32'hA);
        chk("single_ov", 32'(Out_Valid), 32'd1);

        // backpressure with 5 held
        step(1, 0, 0, '0, '0, 1);
        step(0, 1, 0, 4'h5, '0, 1);
        step(0, 1, 0, 4'h5, '0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 4'h6, '0, 0);
        chk("bp_out", 32'(Out), 32'h5);
        step(0, 1, 0, 4'h6, '0, 1);
        chk("bp_load", 32'(Out), 32'h6);

        // mid-burst drop on channel 0
        step(1, 0, 0, '0, '0, 1);
        step(0, 1, 1, 4'h1, 4'h2, 1);
        step(0, 1, 1, 4'h1, 4'h2, 1);
        step(0, 0, 1, 4'h1, 4'h2, 1);
        chk("drop_sel", 32'(Select), 32'd1);
        step(0, 1, 1, 4'h1, 4'h2, 1);
        step(0, 1, 1, 4'h1, 4'h2, 1);
        step(0, 1, 1, 4'h1, 4'h2, 1);

`ifdef GRANT_COUNT_EN
        step(1, 0, 0, '0, '0, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 4'(i), '0, 1);
        chk("gc0_sat", 32'(gc0), 32'd3);
        chk("gc1_zero", 32'(gc1), 32'd0);
        step(1, 1, 1, '0, '0, 1);
        chk("gc0_rst", 32'(gc0), 32'd0);
        chk("gc1_rst", 32'(gc1), 32'd0);
`endif

        // randomized traffic with producer hold rule
        step(1, 0, 0, '0, '0, 1);
        v0 = 0; v1 = 0; d0 = '0; d1 = '0;
        for (int i = 0; i < 400; i++) begin
            bit hold0, hold1;
            hold0 = v0 && m_acc != 0;
            hold1 = v1 && m_acc != 1;
            if (hold0) v0 = ($urandom_range(0, 7) != 0);
            else begin v0 = $urandom_range(0, 3) != 0; d0 = 4'($urandom); end
            if (hold1) v1 = ($urandom_range(0, 7) != 0);
            else begin v1 = $urandom_range(0, 3) != 0; d1 = 4'($urandom); end
            rdy = $urandom_range(0, 3) != 0;
            step(($urandom_range(0, 99) == 0), v0, v1, d0, d1, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
